// File: rtl/custom_pio_pkg.sv
// Shared register map and bus widths for the custom_pio_ext GPIO slave.
package custom_pio_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] REG_DIR      = 3'd1;
    localparam logic [ADDR_W-1:0] REG_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] REG_EDGE_CAP = 3'd3;
    localparam logic [ADDR_W-1:0] REG_OUTSET   = 3'd4;
    localparam logic [ADDR_W-1:0] REG_OUTCLR   = 3'd5;
    localparam logic [ADDR_W-1:0] REG_EDGE_SEL = 3'd6;

endpackage

// File: rtl/pio_bit_debounce.sv
// One GPIO input bit: synchroniser chain, plus a stability counter when
// PIO_DEBOUNCE_EN is defined (otherwise the last sync stage is the filtered value).
module pio_bit_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic filt_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;

    // Counter tracks consecutive cycles where the synchronised pin disagrees
    // with the filtered value; it is cleared on flip, so it can never wrap.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (cnt_q >= CNT_LAST) filt_d = sync_q[SYNC_STAGES-1];
            else                   cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;
`else
    assign filt_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/custom_pio_ext.sv
// Parametrised Avalon-MM GPIO slave: direction, atomic set/clear, edge capture, masked IRQ.
// Optional input debouncing is enabled with the PIO_DEBOUNCE_EN macro.
module custom_pio_ext
    import custom_pio_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter logic [WIDTH-1:0] RESET_OUT       = '0,
    parameter logic [WIDTH-1:0] RESET_DIR       = '0,
    parameter int               DEBOUNCE_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq,
    input  logic [WIDTH-1:0]  pio_in,
    output logic [WIDTH-1:0]  pio_out,
    output logic [WIDTH-1:0]  pio_oe
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic [WIDTH-1:0]  filt, prev_q, edges, wd, clr;
    logic [WIDTH-1:0]  out_q, out_d, dir_q, dir_d, mask_q, mask_d;
    logic [WIDTH-1:0]  cap_q, cap_d, sel_q, sel_d;
    logic [ARM_W-1:0]  arm_q;
    logic              armed, irq_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              unused_wd;

    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_bit_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_i (clk),
            .rst_i (reset),
            .pin_i (pio_in[i]),
            .filt_o(filt[i])
        );
    end

    // Sync/filter flops come out of reset at 0; hold off capture until they
    // reflect the real pins so a high pin at release is not seen as an edge.
    assign armed = (arm_q == ARM_W'(ARM_MAX));
    assign edges = armed ? ((~sel_q & filt & ~prev_q) | (sel_q & ~filt & prev_q)) : '0;
    assign clr   = (write && address == REG_EDGE_CAP) ? wd : '0;

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        sel_d  = sel_q;
        if (write) begin
            case (address)
                REG_DATA:     out_d  = wd;
                REG_DIR:      dir_d  = wd;
                REG_IRQ_MASK: mask_d = wd;
                REG_OUTSET:   out_d  = out_q | wd;
                REG_OUTCLR:   out_d  = out_q & ~wd;
                REG_EDGE_SEL: sel_d  = wd;
                default: ;
            endcase
        end
        // A new edge wins over a simultaneous clear of the same bit.
        cap_d = (cap_q & ~clr) | edges;
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            REG_DATA:                rdata_d = DATA_W'(filt);
            REG_DIR:                 rdata_d = DATA_W'(dir_q);
            REG_IRQ_MASK:            rdata_d = DATA_W'(mask_q);
            REG_EDGE_CAP:            rdata_d = DATA_W'(cap_q);
            REG_OUTSET, REG_OUTCLR:  rdata_d = DATA_W'(out_q);
            REG_EDGE_SEL:            rdata_d = DATA_W'(sel_q);
            default:                 rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= RESET_OUT;
            dir_q   <= RESET_DIR;
            mask_q  <= '0;
            cap_q   <= '0;
            sel_q   <= '0;
            prev_q  <= '0;
            arm_q   <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
            sel_q  <= sel_d;
            prev_q <= filt;
            if (!armed) arm_q <= arm_q + 1'b1;
            if (read)   rdata_q <= rdata_d;
            irq_q  <= |(cap_q & mask_q);
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;
    assign pio_out  = out_q;
    assign pio_oe   = dir_q;

endmodule

// File: tb/tb_custom_pio_ext.sv
// Directed bench for custom_pio_ext with a cycle model of the register/edge/IRQ rules.
module tb_custom_pio_ext;

    localparam int W = 8;
    localparam int S = 2;
`ifdef PIO_DEBOUNCE_EN
    localparam int DB = 8;
`else
    localparam int DB = 0;
`endif
    localparam logic [7:0] R_OUT = 8'h5A;
    localparam logic [7:0] R_DIR = 8'hF0;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        read, write;
    logic [31:0] writedata, readdata, readdata4;
    logic        irq, irq4;
    logic [7:0]  pio_in, pio_out, pio_oe;
    logic [3:0]  pio_in4, pio_out4, pio_oe4;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;
    assign pio_in4 = pio_in[3:0];

    custom_pio_ext #(.WIDTH(W), .SYNC_STAGES(S), .RESET_OUT(R_OUT), .RESET_DIR(R_DIR),
                     .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .irq(irq),
        .pio_in(pio_in), .pio_out(pio_out), .pio_oe(pio_oe));

    custom_pio_ext #(.WIDTH(4), .SYNC_STAGES(S), .RESET_OUT(4'hA), .RESET_DIR(4'h0),
                     .DEBOUNCE_CYCLES(8)) dut4 (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata4), .irq(irq4),
        .pio_in(pio_in4), .pio_out(pio_out4), .pio_oe(pio_oe4));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model of the 8-bit instance ----------------
    logic [7:0]  m_out, m_dir, m_mask, m_cap, m_sel, m_filt, m_prev;
    logic [7:0]  f_old, cap_old, hits, clr, s_old;
    logic        m_irq, m_rd_chk;
    logic [31:0] m_rd;
    int          m_since;
    int          run [W];
    logic [7:0]  pins [$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_out = R_OUT; m_dir = R_DIR; m_mask = '0; m_cap = '0; m_sel = '0;
            m_filt = '0; m_prev = '0; m_irq = 1'b0; m_rd = '0; m_rd_chk = 1'b1;
            m_since = 0;
            pins.delete();
            for (int b = 0; b < W; b++) run[b] = 0;
        end else begin
            f_old   = m_filt;
            cap_old = m_cap;
            m_since++;
            m_rd_chk = read;
            if (read) begin
                case (address)
                    3'd0:       m_rd = {24'h0, f_old};
                    3'd1:       m_rd = {24'h0, m_dir};
                    3'd2:       m_rd = {24'h0, m_mask};
                    3'd3:       m_rd = {24'h0, m_cap};
                    3'd4, 3'd5: m_rd = {24'h0, m_out};
                    3'd6:       m_rd = {24'h0, m_sel};
                    default:    m_rd = '0;
                endcase
            end
            m_irq = |(m_cap & m_mask);
            // Edges only count once S+1 cycles have passed since reset release.
            hits = (m_since >= S + 2) ? ((~m_sel & f_old & ~m_prev) | (m_sel & ~f_old & m_prev)) : 8'h00;
            clr  = (write && address == 3'd3) ? writedata[7:0] : 8'h00;
            if (write) begin
                case (address)
                    3'd0: m_out  = writedata[7:0];
                    3'd1: m_dir  = writedata[7:0];
                    3'd2: m_mask = writedata[7:0];
                    3'd4: m_out  = m_out | writedata[7:0];
                    3'd5: m_out  = m_out & ~writedata[7:0];
                    3'd6: m_sel  = writedata[7:0];
                    default: ;
                endcase
            end
            m_cap = (cap_old & ~clr) | hits;
            s_old = (pins.size() >= S) ? pins[pins.size() - S] : 8'h00;
            pins.push_back(pio_in);
            if (pins.size() > S) void'(pins.pop_front());
`ifdef PIO_DEBOUNCE_EN
            for (int b = 0; b < W; b++) begin
                if (s_old[b] != m_filt[b]) begin
                    run[b]++;
                    if (run[b] == DB) begin
                        m_filt[b] = s_old[b];
                        run[b] = 0;
                    end
                end else run[b] = 0;
            end
`else
            m_filt = (pins.size() >= S) ? pins[pins.size() - S] : 8'h00;
`endif
            m_prev = f_old;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("pio_out", {24'h0, pio_out}, {24'h0, m_out});
        chk("pio_oe",  {24'h0, pio_oe},  {24'h0, m_dir});
        chk("irq",     {31'h0, irq},     {31'h0, m_irq});
        if (m_rd_chk) chk("readdata", readdata, m_rd);
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    logic [31:0] v;

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        pio_in = 8'hFF;
        idle(2);
        chk("rst_out",  {24'h0, pio_out}, 32'h5A);
        chk("rst_oe",   {24'h0, pio_oe},  32'hF0);
        chk("rst_irq",  {31'h0, irq},     32'h0);
        chk("rst_rd",   readdata,         32'h0);
        chk("rst_out4", {28'h0, pio_out4}, 32'hA);
        reset = 1'b0;

        idle(S + DB + 6);
        rd(3'd3, v);
        chk("cap_after_release", v, (DB != 0) ? 32'hFF : 32'h00);

        pio_in = 8'h00;
        wr(3'd0, 32'hA5); chk("out_data",  {24'h0, pio_out}, 32'hA5);
        wr(3'd4, 32'h0F); chk("out_set",   {24'h0, pio_out}, 32'hAF);
        wr(3'd5, 32'h81); chk("out_clr",   {24'h0, pio_out}, 32'h2E);
        rd(3'd5, v);      chk("rd_outclr", v, 32'h2E);

        idle(S + DB + 2);
        pio_in = 8'h3C;
        idle(S + DB);
        rd(3'd0, v);      chk("rd_data_in", v, 32'h3C);
        wr(3'd3, 32'hFF);
        rd(3'd3, v);      chk("cap_cleared", v, 32'h00);

        pio_in = 8'h01;
        idle(S + DB + 3);
        wr(3'd3, 32'hFF);
        wr(3'd6, 32'h01);
        wr(3'd2, 32'h03);
        pio_in = 8'h02;
        idle(S + DB + 2);
        rd(3'd3, v);      chk("cap_rise_fall", v, 32'h03);
        chk("irq_set", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'h01);
        idle(1);
        rd(3'd3, v);      chk("cap_w1c", v, 32'h02);
        chk("irq_held", {31'h0, irq}, 32'h1);

        // Rising edge on bit 2 lands in the same cycle as its W1C.
        pio_in = 8'h06;
        idle(S + DB);
        wr(3'd3, 32'h04);
        rd(3'd3, v);      chk("cap_edge_vs_clr", v, 32'h06);

        wr(3'd2, 32'h00);
        idle(2);
        chk("irq_masked", {31'h0, irq}, 32'h0);

        address = 3'd1; writedata = 32'h3C; read = 1'b1; write = 1'b1;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        chk("rw_same_rd", readdata, 32'hF0);
        chk("rw_same_oe", {24'h0, pio_oe}, 32'h3C);

        wr(3'd1, 32'hFFFF_FFFF);
        rd(3'd1, v);      chk("dir_w8", v, 32'hFF);
        chk("dir_w4", readdata4, 32'h0000_000F);
        rd(3'd7, v);      chk("rd_reserved", v, 32'h0);
        wr(3'd0, 32'h0);
        wr(3'd4, 32'hFFFF_FFFF); chk("set_full", {24'h0, pio_out}, 32'hFF);
        wr(3'd5, 32'h0000_000F); chk("clr_low",  {24'h0, pio_out}, 32'hF0);

`ifdef PIO_DEBOUNCE_EN
        wr(3'd3, 32'hFF);
        pio_in = 8'h86; idle(5);
        pio_in = 8'h06; idle(S + DB + 4);
        rd(3'd3, v);      chk("db_short_cap", v, 32'h00);
        rd(3'd0, v);      chk("db_short_data", v, 32'h06);
        pio_in = 8'h86; idle(12);
        pio_in = 8'h06;
        rd(3'd0, v);      chk("db_long_data", v, 32'h86);
        idle(S + DB + 4);
        rd(3'd3, v);      chk("db_long_cap", v, 32'h80);
`endif

        // Reset arriving with a read in flight discards the read.
        wr(3'd2, 32'h55);
        address = 3'd2; read = 1'b1; reset = 1'b1;
        @(negedge clk);
        read = 1'b0;
        chk("rst_mid_rd",  readdata, 32'h0);
        chk("rst_mid_out", {24'h0, pio_out}, 32'h5A);
        chk("rst_mid_oe",  {24'h0, pio_oe},  32'hF0);
        reset = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
